csr_req_arbiter: RTL and testbench
==================================

// Module: csr_req_arbiter
// PURPOSE
// - Shares the single CSR request/response port between NumReq requesters (e.g. host bus, debug/loader master).
// - Round-robin grant, zero-latency request pass-through, read-response routing back to the issuing requester.
// - Sits directly in front of the CSR block; never reorders, at most one outstanding read.
// PARAMETERS
// - NumReq        2   number of requesters (>=2)
// - CsrDataWidth  32  CSR data width
// - CsrAddrWidth  32  CSR address width
// - ReqIdWidth    $clog2(NumReq)  derived, do not override
// PORTS
// - clk_i            in   1                  clock; all logic on rising edge
// - rst_i            in   1                  reset: one clock; reset is synchronous and active-high
// - req_data_i       in   [NumReq][Data]     per-requester write data
// - req_addr_i       in   [NumReq][Addr]     per-requester address
// - req_write_i      in   [NumReq]           1=write, 0=read
// - req_valid_i      in   [NumReq]           request valid; held with payload until ready
// - req_ready_o      out  [NumReq]           request accepted
// - rsp_data_o       out  [NumReq][Data]     read data (csr_rsp_data_i fanned out to all)
// - rsp_valid_o      out  [NumReq]           read response valid, only to owner
// - rsp_ready_i      in   [NumReq]           requester takes response
// - csr_req_data_o / csr_req_addr_o / csr_req_write_o  out  Data/Addr/1  muxed request payload
// - csr_req_valid_o  out  1                  muxed request valid
// - csr_req_ready_i  in   1                  CSR accepts request
// - csr_rsp_data_i   in   Data               CSR read data
// - csr_rsp_valid_i  in   1                  CSR response valid (may be same cycle as read accept)
// - csr_rsp_ready_o  out  1                  to CSR
// - grant_id_o       out  ReqIdWidth         current/last granted requester (debug)
// - stray_rsp_o      out  1                  pulse: CSR response with no outstanding read
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, lock=0, owner=0; req_ready_o=0, rsp_valid_o=0, csr_req_valid_o=0,
//   csr_rsp_ready_o=1, grant_id_o=0, stray_rsp_o=0.
// - FSM IDLE / WAIT_RSP. IDLE: pick first valid requester scanning rr_ptr, rr_ptr+1, ... mod NumReq.
// - Grant lock: if granted valid not accepted (csr_req_ready_i=0), lock=1 holds grant; no re-arbitration
//   until accepted. Requesters must not drop valid before ready.
// - Pass-through: csr_req_*_o = granted payload, same cycle (0 latency). req_ready_o[g]=csr_req_ready_i&IDLE.
// - Accept (valid&ready): rr_ptr<=g+1 mod NumReq, lock<=0, grant_id_o<=g.
//   - write: stay IDLE; next grant possible next cycle (1 request/cycle throughput for writes).
//   - read with csr_rsp_valid_i & rsp_ready_i[g] same cycle: response routed to g combinationally, stay IDLE.
//   - read otherwise: owner<=g, go WAIT_RSP. If rsp valid but requester not ready, WAIT_RSP holds it (CSR holds).
// - WAIT_RSP: csr_req_valid_o=0, all req_ready_o=0; rsp_valid_o[owner]=csr_rsp_valid_i,
//   csr_rsp_ready_o=rsp_ready_i[owner]; on csr_rsp_valid_i&csr_rsp_ready_o -> IDLE (grant possible next cycle).
// - IDLE with csr_rsp_valid_i and no read accepted this cycle: csr_rsp_ready_o=1 (drain), stray_rsp_o=1 for 1 cycle.
// - rsp_valid_o[i]=0 for every i!=owner/grant; never more than one bit set.
// - rst_i mid-WAIT_RSP: return to IDLE, owner lost; late CSR response then flagged stray_rsp_o.
// - No requester valid: csr_req_valid_o=0, rr_ptr unchanged.
// STRUCTURE
// - csr_arb_pkg: typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} csr_arb_state_e; ArbRstPtr=0.
// - Sub-module rr_arbiter #(NumReq): req vector + rr_ptr -> one-hot grant + index, purely combinational.
// - Top: FSM, rr_ptr/lock/owner regs, payload mux, response demux.
// TESTING
// - Writes from req0 and req1 every cycle, csr ready=1 -> grants alternate 0,1,0,1; 1 write/cycle.
// - req1 read addr 3, CSR responds same cycle 0xA5 -> rsp_valid_o=2'b10, data 0xA5, no WAIT_RSP entry.
// - req0 read, rsp_ready_i[0]=0 for 3 cycles -> WAIT_RSP 3 cycles, req1 write stalled, then resumes next cycle.
// - req0 valid with csr_req_ready_i=0 for 2 cycles, req1 asserts meanwhile -> grant stays 0 until accept.
// - csr_rsp_valid_i=1 in IDLE with no read -> stray_rsp_o pulses 1 cycle, csr_rsp_ready_o=1.
// - rst_i while in WAIT_RSP -> next cycle IDLE, rr_ptr=0, all outputs at reset values.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared types and helpers for the CSR request arbiter.
package csr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} csr_arb_state_e;

    localparam int unsigned ArbRstPtr = 0;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdW    = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdW-1:0]    idx_o,
    output logic              any_o
);

    logic [IdW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdW'((32'(ptr_i) + i) % NumReq);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_req_arbiter.sv
// Shares one CSR request/response port between NumReq requesters with round-robin
// grant, zero-latency request pass-through and single-outstanding-read response routing.
module csr_req_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned CsrDataWidth = 32,
    parameter int unsigned CsrAddrWidth = 32,
    parameter int unsigned ReqIdWidth   = $clog2(NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumReq-1:0][CsrDataWidth-1:0]     req_data_i,
    input  logic [NumReq-1:0][CsrAddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]                       req_write_i,
    input  logic [NumReq-1:0]                       req_valid_i,
    output logic [NumReq-1:0]                       req_ready_o,
    output logic [NumReq-1:0][CsrDataWidth-1:0]     rsp_data_o,
    output logic [NumReq-1:0]                       rsp_valid_o,
    input  logic [NumReq-1:0]                       rsp_ready_i,
    output logic [CsrDataWidth-1:0]                 csr_req_data_o,
    output logic [CsrAddrWidth-1:0]                 csr_req_addr_o,
    output logic                                    csr_req_write_o,
    output logic                                    csr_req_valid_o,
    input  logic                                    csr_req_ready_i,
    input  logic [CsrDataWidth-1:0]                 csr_rsp_data_i,
    input  logic                                    csr_rsp_valid_i,
    output logic                                    csr_rsp_ready_o,
    output logic [ReqIdWidth-1:0]                   grant_id_o,
    output logic                                    stray_rsp_o
);

    csr_arb_state_e          state_q;
    logic [ReqIdWidth-1:0]   rr_ptr_q;
    logic [ReqIdWidth-1:0]   lock_id_q;
    logic [ReqIdWidth-1:0]   owner_q;
    logic                    lock_q;

    logic [NumReq-1:0]       rr_gnt;
    logic [ReqIdWidth-1:0]   rr_idx;
    logic                    rr_any;

    logic                    is_idle;
    logic [ReqIdWidth-1:0]   gnt_idx;
    logic [NumReq-1:0]       gnt_oh;
    logic                    gnt_vld;
    logic                    accept;
    logic                    rd_accept;
    logic                    rd_done_now;
    logic [ReqIdWidth-1:0]   nxt_ptr;

    rr_arbiter #(
        .NumReq (NumReq),
        .IdW    (ReqIdWidth)
    ) u_rr_arbiter (
        .req_i  (req_valid_i),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx),
        .any_o  (rr_any)
    );

    // The CSR response data is fanned out; only rsp_valid_o selects the receiver.
    assign rsp_data_o = {NumReq{csr_rsp_data_i}};

    always_comb begin
        is_idle     = (state_q == ARB_IDLE);
        gnt_idx     = lock_q ? lock_id_q : rr_idx;
        gnt_oh      = lock_q ? (NumReq'(1) << lock_id_q) : rr_gnt;
        gnt_vld     = is_idle && (lock_q ? req_valid_i[lock_id_q] : rr_any);
        accept      = gnt_vld && csr_req_ready_i;
        rd_accept   = accept && !req_write_i[gnt_idx];
        rd_done_now = csr_rsp_valid_i && rsp_ready_i[gnt_idx];
        nxt_ptr     = ReqIdWidth'(rr_wrap_inc(32'(gnt_idx), NumReq));

        csr_req_valid_o = gnt_vld;
        csr_req_data_o  = req_data_i[gnt_idx];
        csr_req_addr_o  = req_addr_i[gnt_idx];
        csr_req_write_o = req_write_i[gnt_idx];
        req_ready_o     = accept ? gnt_oh : '0;

        rsp_valid_o     = '0;
        csr_rsp_ready_o = 1'b1;
        stray_rsp_o     = 1'b0;
        if (!is_idle) begin
            rsp_valid_o[owner_q] = csr_rsp_valid_i;
            csr_rsp_ready_o      = rsp_ready_i[owner_q];
        end else if (rd_accept) begin
            // Read accepted this cycle: a same-cycle response goes straight to the issuer.
            rsp_valid_o[gnt_idx] = csr_rsp_valid_i;
            csr_rsp_ready_o      = rsp_ready_i[gnt_idx];
        end else begin
            stray_rsp_o = csr_rsp_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= ReqIdWidth'(ArbRstPtr);
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            owner_q    <= '0;
            grant_id_o <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        rr_ptr_q   <= nxt_ptr;
                        lock_q     <= 1'b0;
                        grant_id_o <= gnt_idx;
                        if (rd_accept && !rd_done_now) begin
                            owner_q <= gnt_idx;
                            state_q <= ARB_WAIT_RSP;
                        end
                    end else if (gnt_vld) begin
                        // Hold the grant until the CSR accepts the stalled request.
                        lock_q    <= 1'b1;
                        lock_id_q <= gnt_idx;
                    end
                end
                ARB_WAIT_RSP: begin
                    if (csr_rsp_valid_i && csr_rsp_ready_o) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Self-checking bench for csr_req_arbiter: directed vector table, corner sequences, random vs model.
module tb_csr_req_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [31:0] DMASK = 32'hD000_0000;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [N-1:0][DW-1:0]   req_data_i;
    logic [N-1:0][AW-1:0]   req_addr_i;
    logic [N-1:0]           req_write_i;
    logic [N-1:0]           req_valid_i;
    logic [N-1:0]           req_ready_o;
    logic [N-1:0][DW-1:0]   rsp_data_o;
    logic [N-1:0]           rsp_valid_o;
    logic [N-1:0]           rsp_ready_i;
    logic [DW-1:0]          csr_req_data_o;
    logic [AW-1:0]          csr_req_addr_o;
    logic                   csr_req_write_o;
    logic                   csr_req_valid_o;
    logic                   csr_req_ready_i;
    logic [DW-1:0]          csr_rsp_data_i;
    logic                   csr_rsp_valid_i;
    logic                   csr_rsp_ready_o;
    logic                   grant_id_o;
    logic                   stray_rsp_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    csr_req_arbiter #(
        .NumReq       (N),
        .CsrDataWidth (DW),
        .CsrAddrWidth (AW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_data_i      (req_data_i),
        .req_addr_i      (req_addr_i),
        .req_write_i     (req_write_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .csr_req_data_o  (csr_req_data_o),
        .csr_req_addr_o  (csr_req_addr_o),
        .csr_req_write_o (csr_req_write_o),
        .csr_req_valid_o (csr_req_valid_o),
        .csr_req_ready_i (csr_req_ready_i),
        .csr_rsp_data_i  (csr_rsp_data_i),
        .csr_rsp_valid_i (csr_rsp_valid_i),
        .csr_rsp_ready_o (csr_rsp_ready_o),
        .grant_id_o      (grant_id_o),
        .stray_rsp_o     (stray_rsp_o)
    );

    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        cready;
        logic        rvld;
        logic [31:0] rdata;
        logic [1:0]  rrdy;
        logic [1:0]  e_rdy;
        logic        e_cv;
        logic [31:0] e_addr;
        logic        e_cw;
        logic [1:0]  e_rv;
        logic        e_crr;
        logic        e_stray;
        logic        e_gid;
    } vec_t;

    function automatic vec_t mkv(
        input logic [1:0] valid, input logic [1:0] write,
        input logic [31:0] a0, input logic [31:0] a1,
        input logic cready, input logic rvld, input logic [31:0] rdata, input logic [1:0] rrdy,
        input logic [1:0] e_rdy, input logic e_cv, input logic [31:0] e_addr, input logic e_cw,
        input logic [1:0] e_rv, input logic e_crr, input logic e_stray, input logic e_gid);
        vec_t v;
        v.valid = valid;   v.write = write;  v.a0 = a0;         v.a1 = a1;
        v.cready = cready; v.rvld = rvld;    v.rdata = rdata;   v.rrdy = rrdy;
        v.e_rdy = e_rdy;   v.e_cv = e_cv;    v.e_addr = e_addr; v.e_cw = e_cw;
        v.e_rv = e_rv;     v.e_crr = e_crr;  v.e_stray = e_stray; v.e_gid = e_gid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_valid_i     = v.valid;
        req_write_i     = v.write;
        req_addr_i[0]   = v.a0;
        req_addr_i[1]   = v.a1;
        req_data_i[0]   = v.a0 ^ DMASK;
        req_data_i[1]   = v.a1 ^ DMASK;
        csr_req_ready_i = v.cready;
        csr_rsp_valid_i = v.rvld;
        csr_rsp_data_i  = v.rdata;
        rsp_ready_i     = v.rrdy;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v);
        @(negedge clk_i);
        chk({tag, " req_ready"}, 64'(req_ready_o), 64'(v.e_rdy));
        chk({tag, " csr_valid"}, 64'(csr_req_valid_o), 64'(v.e_cv));
        if (v.e_cv) begin
            chk({tag, " csr_addr"}, 64'(csr_req_addr_o), 64'(v.e_addr));
            chk({tag, " csr_data"}, 64'(csr_req_data_o), 64'(v.e_addr ^ DMASK));
            chk({tag, " csr_write"}, 64'(csr_req_write_o), 64'(v.e_cw));
        end
        chk({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'(v.e_rv));
        chk({tag, " csr_rsp_ready"}, 64'(csr_rsp_ready_o), 64'(v.e_crr));
        chk({tag, " stray"}, 64'(stray_rsp_o), 64'(v.e_stray));
        chk({tag, " grant_id"}, 64'(grant_id_o), 64'(v.e_gid));
        chk({tag, " rsp_data0"}, 64'(rsp_data_o[0]), 64'(v.rdata));
        chk({tag, " rsp_data1"}, 64'(rsp_data_o[1]), 64'(v.rdata));
        tick();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive('0);
        tick();
        rst_i = 1'b0;
    endtask

    // Reference model state for the random phase
    bit          m_busy;
    int          m_owner, m_next, m_held, m_last;
    logic [1:0]  pend, pw;
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    vec_t tbl [7];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        tbl[0] = mkv(2'b11, 2'b11, 32'h10, 32'h14, 1'b1, 1'b0, 32'h0, 2'b11,  2'b01, 1'b1, 32'h10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tbl[1] = mkv(2'b11, 2'b11, 32'h10, 32'h14, 1'b1, 1'b0, 32'h0, 2'b11,  2'b10, 1'b1, 32'h14, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tbl[2] = mkv(2'b11, 2'b11, 32'h10, 32'h14, 1'b1, 1'b0, 32'h0, 2'b11,  2'b01, 1'b1, 32'h10, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        tbl[3] = mkv(2'b11, 2'b11, 32'h10, 32'h14, 1'b1, 1'b0, 32'h0, 2'b11,  2'b10, 1'b1, 32'h14, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tbl[4] = mkv(2'b10, 2'b00, 32'h0,  32'h3,  1'b1, 1'b1, 32'hA5, 2'b11, 2'b10, 1'b1, 32'h3,  1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
        tbl[5] = mkv(2'b01, 2'b01, 32'h20, 32'h0,  1'b1, 1'b0, 32'h0, 2'b00,  2'b01, 1'b1, 32'h20, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        tbl[6] = mkv(2'b00, 2'b00, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0, 2'b00,  2'b00, 1'b0, 32'h0,  1'b0, 2'b00, 1'b1, 1'b0, 1'b0);

        rst_i = 1'b1;
        drive('0);
        tick();
        rst_i = 1'b0;
        apply("reset", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));

        for (int i = 0; i < 7; i++) apply($sformatf("T%0d", i), tbl[i]);

        // Read held in WAIT_RSP while the owner is not ready; req1 write stalls.
        do_reset();
        apply("A1", mkv(2'b11, 2'b10, 32'h40, 32'h44, 1'b1, 1'b0, 32'h0, 2'b11, 2'b01, 1'b1, 32'h40, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            apply($sformatf("A_wait%0d", k), mkv(2'b10, 2'b10, 32'h0, 32'h44, 1'b1, 1'b1, 32'h77, 2'b10, 2'b00, 1'b0, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0));
        apply("A5", mkv(2'b10, 2'b10, 32'h0, 32'h44, 1'b1, 1'b1, 32'h77, 2'b11, 2'b00, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0));
        apply("A6", mkv(2'b10, 2'b10, 32'h0, 32'h44, 1'b1, 1'b0, 32'h0, 2'b11, 2'b10, 1'b1, 32'h44, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("A7", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b11, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));

        // Grant lock: with rr_ptr=1, a stalled req0 keeps the grant when req1 appears.
        do_reset();
        apply("B1", mkv(2'b01, 2'b01, 32'h50, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, 32'h50, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("B2", mkv(2'b01, 2'b01, 32'h54, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 32'h54, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("B3", mkv(2'b11, 2'b11, 32'h54, 32'h58, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b1, 32'h54, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("B4", mkv(2'b11, 2'b11, 32'h54, 32'h58, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, 32'h54, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("B5", mkv(2'b10, 2'b10, 32'h0, 32'h58, 1'b1, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 32'h58, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("B6", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));

        // Stray responses while idle are drained and flagged for one cycle.
        apply("C1", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h99, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1));
        apply("C2", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1));
        apply("C3", mkv(2'b01, 2'b01, 32'h60, 32'h0, 1'b1, 1'b1, 32'h66, 2'b00, 2'b01, 1'b1, 32'h60, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1));

        // Reset during WAIT_RSP drops the owner; the late response is stray.
        do_reset();
        apply("D1", mkv(2'b10, 2'b00, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0, 2'b00, 2'b10, 1'b1, 32'h80, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        apply("D2", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1));
        do_reset();
        apply("D3", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0));
        apply("D4", mkv(2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBB, 2'b11, 2'b00, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0));
        apply("E1", mkv(2'b01, 2'b00, 32'h90, 32'h0, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, 32'h90, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0));
        do_reset();
        apply("E2", mkv(2'b11, 2'b11, 32'h94, 32'h98, 1'b1, 1'b0, 32'h0, 2'b00, 2'b01, 1'b1, 32'h94, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0));

        // Random traffic against the reference model
        do_reset();
        m_busy = 0; m_owner = 0; m_next = 0; m_held = -1; m_last = 0;
        pend = '0; pw = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int          g;
            logic [1:0]  e_rdy, e_rv;
            logic        e_cv, e_crr, e_st, rd;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    pw[i]   = 1'($urandom_range(0, 1));
                    pa[i]   = $urandom;
                    pd[i]   = $urandom;
                end
                req_addr_i[i] = pa[i];
                req_data_i[i] = pd[i];
            end
            req_valid_i     = pend;
            req_write_i     = pw;
            csr_req_ready_i = ($urandom_range(0, 3) != 0);
            csr_rsp_valid_i = ($urandom_range(0, 2) == 0);
            csr_rsp_data_i  = $urandom;
            rsp_ready_i     = 2'($urandom_range(0, 3));
            @(negedge clk_i);

            g = -1; e_rdy = '0; e_rv = '0; e_cv = 1'b0; e_crr = 1'b1; e_st = 1'b0; rd = 1'b0;
            if (m_busy) begin
                e_rv[m_owner] = csr_rsp_valid_i;
                e_crr         = rsp_ready_i[m_owner];
            end else begin
                if (m_held >= 0) g = m_held;
                else for (int k = 0; k < 2; k++)
                    if (g < 0 && pend[(m_next + k) % 2]) g = (m_next + k) % 2;
                if (g >= 0) begin
                    e_cv = 1'b1;
                    if (csr_req_ready_i) e_rdy[g] = 1'b1;
                    rd = csr_req_ready_i && !pw[g];
                end
                if (rd) begin
                    e_rv[g] = csr_rsp_valid_i;
                    e_crr   = rsp_ready_i[g];
                end else begin
                    e_st = csr_rsp_valid_i;
                end
            end

            chk("rnd req_ready", 64'(req_ready_o), 64'(e_rdy));
            chk("rnd csr_valid", 64'(csr_req_valid_o), 64'(e_cv));
            if (g >= 0) begin
                chk("rnd csr_addr", 64'(csr_req_addr_o), 64'(pa[g]));
                chk("rnd csr_data", 64'(csr_req_data_o), 64'(pd[g]));
                chk("rnd csr_write", 64'(csr_req_write_o), 64'(pw[g]));
            end
            chk("rnd rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
            chk("rnd csr_rsp_ready", 64'(csr_rsp_ready_o), 64'(e_crr));
            chk("rnd stray", 64'(stray_rsp_o), 64'(e_st));
            chk("rnd grant_id", 64'(grant_id_o), 64'(m_last));
            chk("rnd rsp_data", 64'(rsp_data_o[cyc % 2]), 64'(csr_rsp_data_i));

            if (m_busy) begin
                if (csr_rsp_valid_i && rsp_ready_i[m_owner]) m_busy = 0;
            end else if (g >= 0) begin
                if (csr_req_ready_i) begin
                    pend[g] = 1'b0;
                    m_next  = (g + 1) % 2;
                    m_held  = -1;
                    m_last  = g;
                    if (!pw[g] && !(csr_rsp_valid_i && rsp_ready_i[g])) begin
                        m_busy  = 1;
                        m_owner = g;
                    end
                end else begin
                    m_held = g;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
